// File: rtl/waveform_phase_meter_pkg.sv
// Shared waveform definitions: meter state encoding, default widths and
// hysteresis thresholds, and the waveform generator's HF/LF sample levels.
// Latency: n/a (types and constants only). Backpressure: n/a.
package waveform_phase_meter_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_MEAS_HF = 2'd2,
    ST_MEAS_LF = 2'd3
  } meter_state_e;

  localparam int DEF_SAMPLE_W = 13;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_THR_HI   = 60;
  localparam int DEF_THR_LO   = 40;
  localparam int DEF_TIMEOUT  = 4096;

  // Amplitudes the waveform generator emits for its two phases.
  localparam int GEN_HF_LEVEL = 88;
  localparam int GEN_LF_LEVEL = 13;

  // Encoding of the classified level output.
  localparam logic LEVEL_HF = 1'b1;
  localparam logic LEVEL_LF = 1'b0;

endpackage

// File: rtl/waveform_phase_meter_level_classifier.sv
// Hysteresis classifier: flags a sample as at/above THR_HI or at/below THR_LO.
// Latency: combinational. Backpressure: none, pure function of sample_in.
// Ports: sample_in (unsigned amplitude) -> is_hi, is_lo. Neither flag set
// means the sample is inside the hysteresis band and the caller keeps its level.
module level_classifier #(
  parameter int SAMPLE_W = 13,
  parameter int THR_HI   = 60,
  parameter int THR_LO   = 40
) (
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                is_hi,
  output logic                is_lo
);

  localparam logic [SAMPLE_W-1:0] THR_HI_S = SAMPLE_W'(THR_HI);
  localparam logic [SAMPLE_W-1:0] THR_LO_S = SAMPLE_W'(THR_LO);

  assign is_hi = (sample_in >= THR_HI_S);
  assign is_lo = (sample_in <= THR_LO_S);

endmodule

// File: rtl/waveform_phase_meter.sv
// Measures HF/LF phase lengths of a two-level waveform using a hysteresis slicer.
// Latency: all outputs registered, updated one cycle after the causing sample.
// Backpressure: none; cycles with sample_valid=0 are ignored entirely.
// Ports: clock, reset (sync, active-high); sample_in/sample_valid in;
// level, hf_len, lf_len, meas_valid (pulse), locked, timeout_err (sticky) out.
module waveform_phase_meter
  import waveform_phase_meter_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int THR_HI   = DEF_THR_HI,
  parameter int THR_LO   = DEF_THR_LO,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                level,
  output logic [CNT_W-1:0]    hf_len,
  output logic [CNT_W-1:0]    lf_len,
  output logic                meas_valid,
  output logic                locked,
  output logic                timeout_err
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  meter_state_e     state_q, state_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hf_len_q, hf_len_d;
  logic [CNT_W-1:0] lf_len_q, lf_len_d;
  logic             pair_ok_q, pair_ok_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_err_q, timeout_err_d;

  logic is_hi;
  logic is_lo;
  logic class_lvl;
  logic edge_det;

  level_classifier #(
    .SAMPLE_W (SAMPLE_W),
    .THR_HI   (THR_HI),
    .THR_LO   (THR_LO)
  ) u_classifier (
    .sample_in (sample_in),
    .is_hi     (is_hi),
    .is_lo     (is_lo)
  );

  // In-band samples inherit the registered level, so they can never form an edge.
  assign class_lvl = is_hi ? LEVEL_HF : (is_lo ? LEVEL_LF : level_q);
  assign edge_det  = (class_lvl != level_q);

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    hf_len_d      = hf_len_q;
    lf_len_d      = lf_len_q;
    pair_ok_d     = pair_ok_q;
    locked_d      = locked_q;
    timeout_err_d = timeout_err_q;
    meas_valid_d  = 1'b0;  // single-cycle pulse, never held

    if (sample_valid) begin
      if (state_q == ST_INIT) begin
        // First decisive sample only establishes the starting level.
        if (is_hi || is_lo) begin
          level_d = is_hi;
          state_d = ST_SEEK;
        end
      end else if (edge_det) begin
        level_d = class_lvl;
        cnt_d   = CNT_ONE;
        case (state_q)
          ST_SEEK: begin
            // The phase just ended began before we were watching; don't report it.
            state_d = (class_lvl == LEVEL_HF) ? ST_MEAS_HF : ST_MEAS_LF;
          end
          ST_MEAS_HF: begin
            hf_len_d  = cnt_q;
            pair_ok_d = 1'b1;
            state_d   = ST_MEAS_LF;
          end
          ST_MEAS_LF: begin
            lf_len_d = cnt_q;
            state_d  = ST_MEAS_HF;
            // Only report once an HF phase has been fully measured before this LF.
            if (pair_ok_q) begin
              meas_valid_d = 1'b1;
              locked_d     = 1'b1;
            end
          end
          default: begin
            state_d = ST_INIT;
          end
        endcase
      end else if (cnt_q == TIMEOUT_LAST) begin
        // Waveform stalled: drop lock, keep last lengths and level, resync.
        timeout_err_d = 1'b1;
        locked_d      = 1'b0;
        pair_ok_d     = 1'b0;
        cnt_d         = '0;
        state_d       = ST_SEEK;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_INIT;
      level_q       <= LEVEL_LF;
      cnt_q         <= '0;
      hf_len_q      <= '0;
      lf_len_q      <= '0;
      pair_ok_q     <= 1'b0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      hf_len_q      <= hf_len_d;
      lf_len_q      <= lf_len_d;
      pair_ok_q     <= pair_ok_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign level       = level_q;
  assign hf_len      = hf_len_q;
  assign lf_len      = lf_len_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/waveform_phase_meter.md
WAVEFORM_PHASE_METER -- requirements
Module: waveform_phase_meter

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 13, sample width.
REQ-002 SHALL have parameter CNT_W, default 16, phase-length counter width.
REQ-003 SHALL have parameters THR_HI, default 60, and THR_LO, default 40, which are the hysteresis thresholds.
REQ-004 SHALL have parameter TIMEOUT, default 4096, the maximum number of valid samples allowed without an edge.
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port sample_in  in  SAMPLE_W  waveform amplitude sample, unsigned.
REQ-008 SHALL have port sample_valid  in  1  qualifies sample_in.
REQ-009 SHALL have port level  out  1  classified level: 1 = HF (high), 0 = LF (low).
REQ-010 SHALL have port hf_len  out  CNT_W  last completed HF phase length, in valid samples.
REQ-011 SHALL have port lf_len  out  CNT_W  last completed LF phase length, in valid samples.
REQ-012 SHALL have port meas_valid  out  1  one-cycle pulse when a complete HF+LF pair is reported.
REQ-013 SHALL have port locked  out  1  high while periodic measurement is valid.
REQ-014 SHALL have port timeout_err  out  1  sticky flag: no edge within TIMEOUT valid samples.

Function
REQ-015 SHALL classify each valid sample: sample_in >= THR_HI gives high; sample_in <= THR_LO gives low; any value strictly between the two retains the current level.
REQ-016 SHALL define an edge as a valid sample whose classification differs from the registered level.
REQ-017 SHALL ignore all cycles with sample_valid=0: no state, counter or output changes.
REQ-018 SHALL implement states INIT, SEEK, MEAS_HF and MEAS_LF.
REQ-019 In INIT, on the first valid out-of-band sample, SHALL load level from that sample without treating it as an edge, and go to SEEK; in-band samples leave the block in INIT.
REQ-020 In SEEK, an edge SHALL go to MEAS_HF or MEAS_LF according to the new level, with cnt=1.
REQ-021 In MEAS_HF, an edge SHALL set hf_len<=cnt, pair_ok<=1, state<=MEAS_LF, cnt<=1.
REQ-022 In MEAS_LF, an edge SHALL set lf_len<=cnt, state<=MEAS_HF, cnt<=1; if pair_ok=1, it SHALL also pulse meas_valid and set locked.
REQ-023 A non-edge valid sample SHALL increment cnt, saturating at 2^CNT_W-1.
REQ-024 All outputs SHALL be registered; level, hf_len, lf_len, meas_valid and locked SHALL update in the cycle after the sample that caused the change.
REQ-025 When a valid sample arrives with cnt==TIMEOUT-1 and no edge, in SEEK or either MEAS state, the block SHALL set timeout_err, clear locked and pair_ok, set cnt<=0, go to SEEK, and retain level.
REQ-026 timeout_err SHALL remain set until reset, and SHALL NOT block a later re-lock.
REQ-027 hf_len and lf_len SHALL hold their last values across a timeout.

Reset
REQ-028 On reset, the block SHALL be in INIT with level=0, hf_len=0, lf_len=0, cnt=0, pair_ok=0, meas_valid=0, locked=0 and timeout_err=0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial phase; no meas_valid pulse SHALL be issued for it.

Structure
REQ-030 The state encoding (INIT, SEEK, MEAS_HF, MEAS_LF) and the default threshold and width constants SHALL live in the shared waveform package, alongside the generator's HF/LF level constants.
REQ-031 The hysteresis classifier SHALL be one sub-module, level_classifier, which is combinational and outputs is_hi and is_lo.

Verification
REQ-032 Reset, then feed 3x88, 6x13, 6x88, 6x13, 1x88: hf_len=6 and lf_len=6; exactly one meas_valid pulse, in the cycle after the final 88; locked=1 from that cycle.
REQ-033 While locked on an 88/13 pattern, insert 50 for 2 samples inside an HF phase: no edge occurs; hf_len grows by 2.
REQ-034 Repeat REQ-032 with sample_valid=0 every other cycle: lengths are identical to REQ-032.
REQ-035 After lock, hold 88 for 4096 valid samples: timeout_err=1 and locked=0 after the 4096th sample; a following 13/88/13/88 pattern re-locks while timeout_err stays 1.
REQ-036 Assert reset midway through an LF phase, then feed 13 samples only: all outputs stay at their reset values and no meas_valid pulse occurs.
REQ-037 Feed sample values exactly equal to THR_HI (60) and THR_LO (40): 60 classifies high and 40 classifies low.
